// File: rtl/exc_pkg.sv
// Shared types for the exception sequencer: FSM states, cause codes,
// IorD mux select values and the request-priority / vector-select helpers.
package exc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SAVE = 3'd1,
    ST_ADDR = 3'd2,
    ST_WAIT = 3'd3,
    ST_LOAD = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_OPC  = 2'b01,
    CAUSE_OVF  = 2'b10,
    CAUSE_DIV0 = 2'b11
  } cause_t;

  localparam logic [2:0] SEL_PC   = 3'b000;
  localparam logic [2:0] SEL_B    = 3'b001;
  localparam logic [2:0] SEL_V253 = 3'b010;
  localparam logic [2:0] SEL_V254 = 3'b011;
  localparam logic [2:0] SEL_V255 = 3'b100;

  function automatic logic [2:0] vector_sel(input cause_t c);
    logic [2:0] sel;
    case (c)
      CAUSE_OPC:  sel = SEL_V253;
      CAUSE_OVF:  sel = SEL_V254;
      CAUSE_DIV0: sel = SEL_V255;
      default:    sel = SEL_PC;
    endcase
    return sel;
  endfunction

  // Opcode wins over overflow, overflow over divide-by-zero.
  function automatic cause_t prio_cause(input logic opc, input logic ovf, input logic div0);
    cause_t c;
    if (opc) begin
      c = CAUSE_OPC;
    end else if (ovf) begin
      c = CAUSE_OVF;
    end else if (div0) begin
      c = CAUSE_DIV0;
    end else begin
      c = CAUSE_NONE;
    end
    return c;
  endfunction

endpackage

// File: rtl/exc_wait_counter.sv
// Down-counter that times the memory read latency of the vector fetch.
// Loads a start value, decrements to zero and holds there.
module exc_wait_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = WIDTH'(0);

  logic [WIDTH-1:0] r_count;

  // Count register: load has priority, decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= ZERO;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != ZERO)) begin
      r_count <= r_count - ONE;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_zero = (r_count == ZERO);

endmodule

// File: rtl/exception_sequencer.sv
// Takes over the IorD select and memory write enable while an exception is
// serviced: saves EPC, fetches the handler byte from the vector, loads PC.
module exception_sequencer
  import exc_pkg::*;
#(
  parameter int unsigned MEM_WAIT  = 2,
  parameter logic [31:0] PC_OFFSET = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_ovf,
  input  logic        exc_div0,
  input  logic [2:0]  ctrl_iord_sel,
  input  logic        ctrl_mem_wr,
  input  logic [31:0] pc_in,
  input  logic [7:0]  mem_byte,
  output logic [2:0]  iord_sel,
  output logic        mem_wr,
  output logic        epc_wr,
  output logic [31:0] epc_val,
  output logic        pc_load,
  output logic [31:0] pc_load_val,
  output logic [1:0]  cause,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(MEM_WAIT) + 1;
  localparam logic [CW-1:0] WAIT_INIT = CW'(MEM_WAIT - 1);

  state_t r_state;
  state_t w_next;
  cause_t r_cause;
  cause_t w_req_cause;
  logic   w_any_req;
  logic   w_wait_zero;

  assign w_any_req   = exc_opcode | exc_ovf | exc_div0;
  assign w_req_cause = prio_cause(exc_opcode, exc_ovf, exc_div0);
  assign cause       = r_cause;

  exc_wait_counter #(.WIDTH(CW)) u_wait (
    .clk        (clk),
    .reset      (reset),
    .i_load     (r_state == ST_ADDR),
    .i_load_val (WAIT_INIT),
    .i_dec      (r_state == ST_WAIT),
    .o_zero     (w_wait_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Cause is captured only when a request is accepted and held afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cause <= CAUSE_NONE;
    end else if ((r_state == ST_IDLE) && w_any_req) begin
      r_cause <= w_req_cause;
    end else begin
      r_cause <= r_cause;
    end
  end

  // Next state and outputs; reset forces pass-through with no strobes.
  always_comb begin
    w_next      = r_state;
    iord_sel    = ctrl_iord_sel;
    mem_wr      = ctrl_mem_wr;
    epc_wr      = 1'b0;
    epc_val     = 32'd0;
    pc_load     = 1'b0;
    pc_load_val = 32'd0;
    busy        = 1'b0;
    done        = 1'b0;
    if (reset) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            w_next = ST_SAVE;
          end else begin
            w_next = ST_IDLE;
          end
        end
        ST_SAVE: begin
          busy    = 1'b1;
          mem_wr  = 1'b0;
          epc_wr  = 1'b1;
          epc_val = pc_in - PC_OFFSET;
          w_next  = ST_ADDR;
        end
        ST_ADDR: begin
          busy     = 1'b1;
          mem_wr   = 1'b0;
          iord_sel = vector_sel(r_cause);
          w_next   = ST_WAIT;
        end
        ST_WAIT: begin
          busy     = 1'b1;
          mem_wr   = 1'b0;
          iord_sel = vector_sel(r_cause);
          if (w_wait_zero) begin
            w_next = ST_LOAD;
          end else begin
            w_next = ST_WAIT;
          end
        end
        ST_LOAD: begin
          busy        = 1'b1;
          mem_wr      = 1'b0;
          iord_sel    = vector_sel(r_cause);
          pc_load     = 1'b1;
          pc_load_val = {24'd0, mem_byte};
          w_next      = ST_DONE;
        end
        ST_DONE: begin
          busy   = 1'b1;
          mem_wr = 1'b0;
          done   = 1'b1;
          w_next = ST_IDLE;
        end
        default: begin
          w_next = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer: a MEM_WAIT=2 instance checked cycle by
// cycle plus a scoreboard for EPC/PC/cause, and a MEM_WAIT=1 instance alongside.
module tb_exception_sequencer;
  import exc_pkg::*;

  localparam int MW  = 2;
  localparam int MW1 = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_opcode, exc_ovf, exc_div0;
  logic [2:0]  ctrl_iord_sel;
  logic        ctrl_mem_wr;
  logic [31:0] pc_in;
  logic [7:0]  mem_byte;

  logic [2:0]  iord_sel, m1_iord_sel;
  logic        mem_wr, m1_mem_wr;
  logic        epc_wr, m1_epc_wr;
  logic [31:0] epc_val, m1_epc_val;
  logic        pc_load, m1_pc_load;
  logic [31:0] pc_load_val, m1_pc_load_val;
  logic [1:0]  cause, m1_cause;
  logic        busy, m1_busy;
  logic        done, m1_done;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] q_epc[$];
  logic [31:0] q_pcl[$];
  logic [1:0]  q_cause[$];

  always #5 clk = ~clk;

  exception_sequencer #(.MEM_WAIT(MW), .PC_OFFSET(32'd4)) dut (
    .clk(clk), .reset(reset), .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
    .ctrl_iord_sel(ctrl_iord_sel), .ctrl_mem_wr(ctrl_mem_wr), .pc_in(pc_in), .mem_byte(mem_byte),
    .iord_sel(iord_sel), .mem_wr(mem_wr), .epc_wr(epc_wr), .epc_val(epc_val), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .cause(cause), .busy(busy), .done(done)
  );

  exception_sequencer #(.MEM_WAIT(MW1), .PC_OFFSET(32'd4)) dut1 (
    .clk(clk), .reset(reset), .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
    .ctrl_iord_sel(ctrl_iord_sel), .ctrl_mem_wr(ctrl_mem_wr), .pc_in(pc_in), .mem_byte(mem_byte),
    .iord_sel(m1_iord_sel), .mem_wr(m1_mem_wr), .epc_wr(m1_epc_wr), .epc_val(m1_epc_val),
    .pc_load(m1_pc_load), .pc_load_val(m1_pc_load_val), .cause(m1_cause), .busy(m1_busy), .done(m1_done)
  );

  task automatic chk_w(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_b(input string tag, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every strobe must consume an expectation pushed at request time.
  always @(negedge clk) begin
    if (epc_wr) begin
      chk_b("epc_pending", q_epc.size() != 0, 1'b1);
      if (q_epc.size() != 0) chk_w("epc_val", epc_val, q_epc.pop_front());
    end
    if (pc_load) begin
      chk_b("pcl_pending", q_pcl.size() != 0, 1'b1);
      if (q_pcl.size() != 0) chk_w("pc_load_val", pc_load_val, q_pcl.pop_front());
    end
    if (done) begin
      chk_b("done_pending", q_cause.size() != 0, 1'b1);
      if (q_cause.size() != 0) chk_w("done_cause", 32'(cause), 32'(q_cause.pop_front()));
    end
  end

  task automatic run_seq(input logic [2:0] req, input logic [31:0] pc, input logic [7:0] mb,
                         input logic [2:0] csel, input logic cwr, input logic [2:0] exp_sel,
                         input logic [1:0] exp_cause, input logic [31:0] exp_epc, input int repulse);
    logic e_busy;
    @(posedge clk); #1;
    {exc_opcode, exc_ovf, exc_div0} = req;
    pc_in = pc; mem_byte = mb; ctrl_iord_sel = csel; ctrl_mem_wr = cwr;
    q_epc.push_back(exp_epc);
    q_pcl.push_back({24'h0, mb});
    q_cause.push_back(exp_cause);
    @(negedge clk);
    chk_b("c0_busy", busy, 1'b0);
    for (int c = 1; c <= MW + 6; c++) begin
      @(posedge clk); #1;
      if (c == repulse) exc_ovf = 1'b1;
      else {exc_opcode, exc_ovf, exc_div0} = 3'b000;
      @(negedge clk);
      e_busy = (c <= MW + 4);
      chk_b("busy", busy, e_busy);
      chk_b("epc_wr", epc_wr, c == 1);
      chk_b("pc_load", pc_load, c == MW + 3);
      chk_b("done", done, c == MW + 4);
      chk_w("iord_sel", 32'(iord_sel), 32'((c >= 2 && c <= MW + 3) ? exp_sel : csel));
      chk_b("mem_wr", mem_wr, e_busy ? 1'b0 : cwr);
      chk_w("cause", 32'(cause), 32'(exp_cause));
      chk_b("m1_busy", m1_busy, c <= MW1 + 4);
      chk_b("m1_pc_load", m1_pc_load, c == MW1 + 3);
      if (c == MW1 + 3) chk_w("m1_pc_load_val", m1_pc_load_val, {24'h0, mb});
    end
  endtask

  initial begin
    logic [2:0] sels[3];
    sels = '{SEL_PC, SEL_B, 3'b101};
    reset = 1'b1;
    {exc_opcode, exc_ovf, exc_div0} = 3'b000;
    ctrl_iord_sel = SEL_PC; ctrl_mem_wr = 1'b0; pc_in = 32'd0; mem_byte = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_done", done, 1'b0);
    chk_b("rst_epc_wr", epc_wr, 1'b0);
    chk_b("rst_pc_load", pc_load, 1'b0);
    chk_w("rst_cause", 32'(cause), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Overflow with the spec's reference values.
    run_seq(3'b010, 32'h0000_0040, 8'h80, SEL_B, 1'b0, SEL_V254, 2'b10, 32'h0000_003C, 0);
    // Simultaneous opcode and div0: opcode wins, div0 dropped.
    run_seq(3'b101, 32'h0000_1000, 8'h12, SEL_PC, 1'b0, SEL_V253, 2'b01, 32'h0000_0FFC, 0);

    // Idle pass-through, same cycle.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      ctrl_iord_sel = sels[i]; ctrl_mem_wr = 1'b1;
      @(negedge clk);
      chk_w("pass_sel", 32'(iord_sel), 32'(sels[i]));
      chk_b("pass_wr", mem_wr, 1'b1);
    end
    run_seq(3'b001, 32'h0000_0200, 8'h44, 3'b101, 1'b1, SEL_V255, 2'b11, 32'h0000_01FC, 0);

    // Reset during WAIT: no pc_load, cause cleared.
    @(posedge clk); #1;
    ctrl_iord_sel = SEL_B; ctrl_mem_wr = 1'b0; pc_in = 32'h0000_0100; exc_ovf = 1'b1;
    q_epc.push_back(32'h0000_00FC);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      exc_ovf = 1'b0;
      reset = (c == 3);
      @(negedge clk);
      chk_b("rst_mid_pc_load", pc_load, 1'b0);
      if (c >= 4) begin
        chk_b("rst_mid_busy", busy, 1'b0);
        chk_w("rst_mid_cause", 32'(cause), 32'd0);
        chk_w("rst_mid_sel", 32'(iord_sel), 32'(SEL_B));
      end
    end

    // Overflow re-pulsed during WAIT is ignored.
    run_seq(3'b010, 32'h0000_0080, 8'h33, SEL_PC, 1'b0, SEL_V254, 2'b10, 32'h0000_007C, 4);
    // EPC wrap at pc_in = 0, handler byte 0xFF.
    run_seq(3'b010, 32'h0000_0000, 8'hFF, SEL_PC, 1'b0, SEL_V254, 2'b10, 32'hFFFF_FFFC, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_w("scoreboard_drained", 32'(q_epc.size() + q_pcl.size() + q_cause.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
